// File: rtl/vita_rx_control_multichan.sv
// vita_rx_control_multichan: multi-lane VITA RX control stage.
// Executes timed stream commands from the settings bus. Each strobed set of
// lane samples becomes one timestamped word in a single-entry output register.
// Late commands and overruns are reported as error words.
// Optional feature macro: VRX_IQ_SWAP_EN (per-lane I/Q half swap, BASE+3 mask).
module vita_rx_control_multichan #(
  parameter int BASE  = 0,
  parameter int NCHAN = 1,
  parameter int WIDTH = 32,
  parameter int CNTW  = 28
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        set_stb,
  input  logic [7:0]                  set_addr,
  input  logic [31:0]                 set_data,
  input  logic [63:0]                 vita_time,
  input  logic [NCHAN*WIDTH-1:0]      sample,
  input  logic                        strobe,
  output logic                        run,
  output logic                        overrun,
  output logic [68+NCHAN*WIDTH-1:0]   sample_fifo_o,
  output logic                        sample_fifo_src_rdy_o,
  input  logic                        sample_fifo_dst_rdy_i,
  output logic [31:0]                 debug
);

  localparam int SW = NCHAN*WIDTH;
  localparam int OW = 68 + SW;
  localparam logic [7:0] ADDR_CMD = 8'(BASE);
  localparam logic [7:0] ADDR_HI  = 8'(BASE + 1);
  localparam logic [7:0] ADDR_LO  = 8'(BASE + 2);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RUN = 2'd2, S_ERR = 2'd3} state_t;

  // ---------------- settings registers ----------------
  logic            cmd_now_q, cmd_now_d, cmd_reload_q, cmd_reload_d, cmd_stop_q, cmd_stop_d;
  logic [CNTW-1:0] cmd_lines_q, cmd_lines_d;
  logic [31:0]     time_hi_q, time_hi_d, time_lo_q, time_lo_d;
  logic            commit_q, commit_d;
  logic            unused_set;

  // command bits 30 and any bits above num_lines carry nothing
  assign unused_set = ^set_data;

  // decode settings-bus writes; a time_lo write arms the commit pulse
  always_comb begin
    cmd_now_d    = cmd_now_q;
    cmd_reload_d = cmd_reload_q;
    cmd_stop_d   = cmd_stop_q;
    cmd_lines_d  = cmd_lines_q;
    time_hi_d    = time_hi_q;
    time_lo_d    = time_lo_q;
    commit_d     = 1'b0;
    if (set_stb) begin
      if (set_addr == ADDR_CMD) begin
        cmd_now_d    = set_data[31];
        cmd_reload_d = set_data[29];
        cmd_stop_d   = set_data[28];
        cmd_lines_d  = set_data[CNTW-1:0];
      end
      if (set_addr == ADDR_HI) time_hi_d = set_data;
      if (set_addr == ADDR_LO) begin
        time_lo_d = set_data;
        commit_d  = 1'b1;
      end
    end
  end

  // settings survive clear; only the pending commit pulse is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_now_q    <= 1'b0;
      cmd_reload_q <= 1'b0;
      cmd_stop_q   <= 1'b0;
      cmd_lines_q  <= '0;
      time_hi_q    <= '0;
      time_lo_q    <= '0;
      commit_q     <= 1'b0;
    end else begin
      cmd_now_q    <= cmd_now_d;
      cmd_reload_q <= cmd_reload_d;
      cmd_stop_q   <= cmd_stop_d;
      cmd_lines_q  <= cmd_lines_d;
      time_hi_q    <= time_hi_d;
      time_lo_q    <= time_lo_d;
      commit_q     <= clear ? 1'b0 : commit_d;
    end
  end

  // ---------------- optional per-lane I/Q swap ----------------
  logic [SW-1:0] sample_sw;
`ifdef VRX_IQ_SWAP_EN
  localparam logic [7:0] ADDR_SWAP = 8'(BASE + 3);
  logic [NCHAN-1:0] iq_swap_q, iq_swap_d;

  // swap mask register, kept across clear like the other settings
  always_comb begin
    iq_swap_d = iq_swap_q;
    if (set_stb && set_addr == ADDR_SWAP) iq_swap_d = set_data[NCHAN-1:0];
  end

  // mask register update
  always_ff @(posedge clk) begin
    if (reset) iq_swap_q <= '0;
    else       iq_swap_q <= iq_swap_d;
  end

  for (genvar i = 0; i < NCHAN; i++) begin : g_lane
    assign sample_sw[i*WIDTH +: WIDTH] = iq_swap_q[i] ?
      {sample[i*WIDTH +: WIDTH/2], sample[i*WIDTH+WIDTH/2 +: WIDTH/2]} :
      sample[i*WIDTH +: WIDTH];
  end
`else
  assign sample_sw = sample;
`endif

  // ---------------- control FSM and output register ----------------
  state_t          state_q, state_d;
  logic [CNTW-1:0] count_q, count_d, act_lines_q, act_lines_d;
  logic            act_now_q, act_now_d, act_reload_q, act_reload_d;
  logic [63:0]     act_time_q, act_time_d;
  logic            sob_pend_q, sob_pend_d, stop_pend_q, stop_pend_d;
  logic [67:0]     err_word_q, err_word_d;   // {eob, overrun, late, sob, time}
  logic            err_loaded_q, err_loaded_d;
  logic            full_q, full_d, run_q, run_d, overrun_q, overrun_d;
  logic [OW-1:0]   out_q, out_d;
  logic            loadable, accept, stop_eff, last, load;
  logic [OW-1:0]   load_word;

  assign loadable = !full_q || sample_fifo_dst_rdy_i;
  assign accept   = full_q && sample_fifo_dst_rdy_i;
  // a stop commit landing with a strobe already ends the burst on that strobe
  assign stop_eff = stop_pend_q || (commit_q && cmd_stop_q);
  assign last     = ((act_lines_q != '0) && (count_q == act_lines_q - CNTW'(1))) || stop_eff;

  // next-state, output-register load and error-word capture
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    act_lines_d  = act_lines_q;
    act_now_d    = act_now_q;
    act_reload_d = act_reload_q;
    act_time_d   = act_time_q;
    sob_pend_d   = sob_pend_q;
    stop_pend_d  = stop_pend_q;
    err_word_d   = err_word_q;
    err_loaded_d = err_loaded_q;
    overrun_d    = 1'b0;
    load         = 1'b0;
    load_word    = '0;
    case (state_q)
      S_IDLE: begin
        if (commit_q && !cmd_stop_q) begin
          state_d      = S_WAIT;
          act_lines_d  = cmd_lines_q;
          act_now_d    = cmd_now_q;
          act_reload_d = cmd_reload_q;
          act_time_d   = {time_hi_q, time_lo_q};
          count_d      = '0;
          stop_pend_d  = 1'b0;
        end
      end
      S_WAIT: begin
        if (commit_q && cmd_stop_q) begin
          state_d = S_IDLE;
        end else if (act_now_q || vita_time == act_time_q) begin
          state_d    = S_RUN;
          sob_pend_d = 1'b1;
          count_d    = '0;
        end else if (vita_time > act_time_q) begin
          state_d      = S_ERR;
          err_word_d   = {4'b1010, vita_time};
          err_loaded_d = 1'b0;
        end
      end
      S_RUN: begin
        if (commit_q && cmd_stop_q) stop_pend_d = 1'b1;
        if (strobe) begin
          if (loadable) begin
            load       = 1'b1;
            load_word  = {last, 2'b00, sob_pend_q, vita_time, sample_sw};
            sob_pend_d = 1'b0;
            count_d    = count_q + CNTW'(1);
            if (last) begin
              count_d = '0;
              if (act_reload_q && !stop_eff) begin
                sob_pend_d = 1'b1;
              end else begin
                state_d     = S_IDLE;
                stop_pend_d = 1'b0;
              end
            end
          end else begin
            overrun_d    = 1'b1;
            state_d      = S_ERR;
            err_word_d   = {4'b1100, vita_time};
            err_loaded_d = 1'b0;
          end
        end
      end
      S_ERR: begin
        if (!err_loaded_q) begin
          if (loadable) begin
            load         = 1'b1;
            load_word    = {err_word_q, {SW{1'b0}}};
            err_loaded_d = 1'b1;
          end
        end else if (accept) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    full_d = load ? 1'b1 : (accept ? 1'b0 : full_q);
    out_d  = load ? load_word : out_q;
    run_d  = (state_d == S_RUN);
  end

  // FSM and output register; reset and clear both return to an empty IDLE
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      act_lines_q  <= '0;
      act_now_q    <= 1'b0;
      act_reload_q <= 1'b0;
      act_time_q   <= '0;
      sob_pend_q   <= 1'b0;
      stop_pend_q  <= 1'b0;
      err_word_q   <= '0;
      err_loaded_q <= 1'b0;
      full_q       <= 1'b0;
      out_q        <= '0;
      run_q        <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      act_lines_q  <= act_lines_d;
      act_now_q    <= act_now_d;
      act_reload_q <= act_reload_d;
      act_time_q   <= act_time_d;
      sob_pend_q   <= sob_pend_d;
      stop_pend_q  <= stop_pend_d;
      err_word_q   <= err_word_d;
      err_loaded_q <= err_loaded_d;
      full_q       <= full_d;
      out_q        <= out_d;
      run_q        <= run_d;
      overrun_q    <= overrun_d;
    end
  end

  assign run                   = run_q;
  assign overrun               = overrun_q;
  assign sample_fifo_o         = out_q;
  assign sample_fifo_src_rdy_o = full_q;
  assign debug                 = {state_q, full_q, strobe, 28'(count_q)};

endmodule
